mem_operand_server: RTL and testbench
=====================================

MEM_OPERAND_SERVER -- requirements
Module: mem_operand_server

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of operands and results.
REQ-002 SHALL have parameter DEPTH, default 8, number of operand pairs and result slots; address width is log2(DEPTH) = 3.
REQ-003 SHALL have parameter LAT, default 2, ALU result latency in cycles (range 1..15).
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 Wr_En  in  1  operand-pair write strobe.
REQ-007 Wr_Addr  in  3  operand slot written.
REQ-008 Wr_X, Wr_Y  in  16 each  operand pair written.
REQ-009 Start  in  1  one-cycle request to run a batch.
REQ-010 Count  in  4  number of pairs in the batch, sampled with Start.
REQ-011 Mem_Data_X, Mem_Data_Y  out  16 each  registered operands presented to the ALU.
REQ-012 Z  in  16  ALU result.
REQ-013 Rd_Addr  in  3  result slot read address.
REQ-014 Rd_Data  out  16  registered result read data.
REQ-015 Busy  out  1  high in ISSUE and WAIT.
REQ-016 Done  out  1  one-cycle pulse at batch completion.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: Start=1 with 1<=Count<=DEPTH -> latch Count, index=0, go to ISSUE; Count=0 or Count>DEPTH -> stay IDLE, no other effect.
REQ-019 ISSUE (one cycle): at its closing edge load Mem_Data_X/Y from operand slot[index], clear wait counter, go to WAIT.
REQ-020 WAIT: increment wait counter each cycle; at the LAT-th WAIT edge capture Z into result slot[index].
REQ-021 After capture: if index==Count-1 go to DONE, else index+1 and go to ISSUE.
REQ-022 DONE: Done=1 for exactly that cycle, then IDLE.
REQ-023 Per-pair cost SHALL be 1+LAT cycles; batch of N SHALL assert Done N*(1+LAT)+1 cycles after the Start edge.
REQ-024 Mem_Data_X/Y SHALL hold their last value between loads and in IDLE.
REQ-025 Wr_En SHALL write operand slot[Wr_Addr] only in IDLE; ignored otherwise.
REQ-026 Start while not IDLE SHALL be ignored.
REQ-027 Wr_En and Start in the same IDLE cycle: write completes first; a batch covering Wr_Addr uses the new data.
REQ-028 Rd_Data SHALL equal result slot[Rd_Addr] one cycle after Rd_Addr is sampled; a read of a slot written at the same edge returns the old value.
REQ-029 Operand and result values SHALL be passed bit-exact, no sign or width conversion.

Reset
REQ-030 RST high SHALL immediately force IDLE; index, wait counter, Mem_Data_X, Mem_Data_Y, Rd_Data, Busy, Done = 0; all operand and result slots = 0.
REQ-031 RST mid-batch SHALL abandon the batch with no Done pulse; first Start accepted on the first rising edge after RST falls.

Structure
REQ-032 FSM state encodings, WIDTH, DEPTH defaults SHALL be in shared package alu_pkg.
REQ-033 Storage SHALL be one sub-module, pair_regfile (two write-gated 16-bit arrays plus result array, registered read).

Verification
REQ-034 Write slot0 = (0xFFF3, 0xFFF7) (-13, -9), Start Count=1, ALU model Z=X+Y, LAT=2 -> Mem_Data_X=0xFFF3, Mem_Data_Y=0xFFF7 after ISSUE; result slot0=0xFFEA; Done 4 cycles after Start.
REQ-035 Load 8 pairs (k, 2k), Start Count=8 -> results 3k for k=0..7, Done at cycle 25, Busy high cycles 1..24.
REQ-036 Start with Count=0 and Count=9 -> FSM stays IDLE, Busy and Done never assert.
REQ-037 Start and Wr_En during a 4-pair batch -> both ignored; operand slots unchanged; exactly one Done.
REQ-038 RST pulsed during WAIT of pair 2 -> all outputs 0 immediately, no Done; a new Start runs a full batch correctly.
REQ-039 Start in the same cycle as Wr_En to slot0 with new data (0x0001, 0x0002) -> result slot0=0x0003.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the memory operand server: default sizes, the FSM
// state encoding and a helper that qualifies a requested batch length.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH_DEF = 16;   // operand / result width
   localparam int DEPTH_DEF = 8;    // operand pairs and result slots
   localparam int LAT_DEF   = 2;    // ALU result latency in cycles

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // A batch is runnable only if it covers at least one pair and no more
   // pairs than there are slots.
   function automatic logic count_ok(input logic [7:0] count, input int depth);
      return (count != 8'd0) && (int'(count) <= depth);
   endfunction

endpackage

// File: rtl/mem_operand_server_if.sv
// -----------------------------------------------------------------------------
// mem_operand_server_if
// Bus bundle between a host and mem_operand_server. Signal prefixes are from
// the server's point of view (i_ = into the server, o_ = out of it).
//   i_wr_en/i_wr_addr/i_wr_x/i_wr_y : operand-pair write port
//   i_start/i_count                 : batch request and its pair count
//   o_mem_data_x/o_mem_data_y       : registered operands to the ALU
//   i_z                             : ALU result
//   i_rd_addr/o_rd_data             : result read port (1-cycle latency)
//   o_busy/o_done                   : batch status
// Modports: master = host side, slave = server side.
// -----------------------------------------------------------------------------
interface mem_operand_server_if
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic             i_wr_en;
   logic [AW-1:0]    i_wr_addr;
   logic [WIDTH-1:0] i_wr_x;
   logic [WIDTH-1:0] i_wr_y;
   logic             i_start;
   logic [CW-1:0]    i_count;
   logic [WIDTH-1:0] o_mem_data_x;
   logic [WIDTH-1:0] o_mem_data_y;
   logic [WIDTH-1:0] i_z;
   logic [AW-1:0]    i_rd_addr;
   logic [WIDTH-1:0] o_rd_data;
   logic             o_busy;
   logic             o_done;

   modport master (
      output i_wr_en, i_wr_addr, i_wr_x, i_wr_y, i_start, i_count, i_z, i_rd_addr,
      input  o_mem_data_x, o_mem_data_y, o_rd_data, o_busy, o_done
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_x, i_wr_y, i_start, i_count, i_z, i_rd_addr,
      output o_mem_data_x, o_mem_data_y, o_rd_data, o_busy, o_done
   );

endinterface

// File: rtl/pair_regfile.sv
// -----------------------------------------------------------------------------
// pair_regfile
// Operand-pair storage (X and Y arrays) plus result array.
//   clk, rst            : clock, async active-high reset (clears everything)
//   i_wr_en/addr/x/y    : operand pair write (caller gates it to IDLE)
//   i_op_load/i_op_addr : load the output operand registers from a slot
//   o_op_x/o_op_y       : registered operands, hold between loads
//   i_res_we/addr/data  : result slot write
//   i_rd_addr/o_rd_data : registered result read, returns pre-write data on a
//                         same-edge write to the same slot
// -----------------------------------------------------------------------------
module pair_regfile
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_x,
   input  logic [WIDTH-1:0] i_wr_y,
   input  logic             i_op_load,
   input  logic [AW-1:0]    i_op_addr,
   output logic [WIDTH-1:0] o_op_x,
   output logic [WIDTH-1:0] o_op_y,
   input  logic             i_res_we,
   input  logic [AW-1:0]    i_res_addr,
   input  logic [WIDTH-1:0] i_res_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_op_x [DEPTH];
   logic [WIDTH-1:0] r_op_y [DEPTH];
   logic [WIDTH-1:0] r_res  [DEPTH];
   logic [WIDTH-1:0] r_mem_x;
   logic [WIDTH-1:0] r_mem_y;
   logic [WIDTH-1:0] r_rd_data;

   // NOTE: every slot must read as zero after reset, so the arrays are built
   // from resettable flops rather than a RAM macro (which cannot be reset).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_op_x[i] <= '0;
            r_op_y[i] <= '0;
            r_res[i]  <= '0;
         end
         r_mem_x   <= '0;
         r_mem_y   <= '0;
         r_rd_data <= '0;
      end else begin
         // NOTE: non-blocking assignment gives read-old-value semantics: a
         // read and a write of the same slot on one edge see the prior data.
         if (i_wr_en) begin
            r_op_x[i_wr_addr] <= i_wr_x;
            r_op_y[i_wr_addr] <= i_wr_y;
         end
         if (i_op_load) begin
            r_mem_x <= r_op_x[i_op_addr];
            r_mem_y <= r_op_y[i_op_addr];
         end
         if (i_res_we) begin
            r_res[i_res_addr] <= i_res_data;
         end
         r_rd_data <= r_res[i_rd_addr];
      end
   end

   assign o_op_x    = r_mem_x;
   assign o_op_y    = r_mem_y;
   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_operand_server.sv
// -----------------------------------------------------------------------------
// mem_operand_server
// Streams a batch of stored operand pairs to an external ALU one pair at a
// time, waits LAT cycles per pair and stores each ALU result in the result
// slot of the same index. Each pair costs 1 ISSUE + LAT WAIT cycles; Done
// pulses for one cycle in DONE.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : mem_operand_server_if.slave (write port, batch control, ALU
//         operands/result, result read port, busy/done)
// -----------------------------------------------------------------------------
module mem_operand_server
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int LAT   = LAT_DEF
) (
   input logic                 clk,
   input logic                 rst,
   mem_operand_server_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   state_t        r_state;
   logic [AW-1:0] r_index;
   logic [CW-1:0] r_count;
   logic [3:0]    r_wait_cnt;
   logic          r_busy;
   logic          r_done;

   logic w_wait_last;
   logic w_last_pair;
   logic w_start_ok;
   logic w_wr_en;
   logic w_op_load;
   logic w_res_we;

   // The LAT-th WAIT edge is the one where the counter still reads LAT-1.
   assign w_wait_last = (r_wait_cnt == 4'(LAT - 1));
   assign w_last_pair = ({1'b0, r_index} == (r_count - 1'b1));
   assign w_start_ok  = bus.i_start && count_ok(8'(bus.i_count), DEPTH);

   // Host writes are only honoured while idle so a running batch sees a
   // stable operand set.
   assign w_wr_en   = bus.i_wr_en && (r_state == S_IDLE);
   assign w_op_load = (r_state == S_ISSUE);
   assign w_res_we  = (r_state == S_WAIT) && w_wait_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_count    <= '0;
         r_wait_cnt <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_count <= bus.i_count;
                  r_index <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + 4'd1;
               if (w_wait_last) begin
                  if (w_last_pair) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_index <= r_index + 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   pair_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (bus.i_wr_addr),
      .i_wr_x     (bus.i_wr_x),
      .i_wr_y     (bus.i_wr_y),
      .i_op_load  (w_op_load),
      .i_op_addr  (r_index),
      .o_op_x     (bus.o_mem_data_x),
      .o_op_y     (bus.o_mem_data_y),
      .i_res_we   (w_res_we),
      .i_res_addr (r_index),
      .i_res_data (bus.i_z),
      .i_rd_addr  (bus.i_rd_addr),
      .o_rd_data  (bus.o_rd_data)
   );

   assign bus.o_busy = r_busy;
   assign bus.o_done = r_done;

endmodule

// File: tb/tb_mem_operand_server.sv
// -----------------------------------------------------------------------------
// tb_mem_operand_server
// Directed bench for mem_operand_server (WIDTH=16, DEPTH=8, LAT=2) with an
// adder as the ALU. Expected results are pushed to a scoreboard when a batch
// starts and compared against the result read port after Done.
// -----------------------------------------------------------------------------
module tb_mem_operand_server;
   import alu_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int LAT   = 2;
   localparam int PAIR  = 1 + LAT;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] value;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_operand_server_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   mem_operand_server #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LAT   (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ALU model: Z = X + Y, 16-bit wrap.
   assign bus.i_z = bus.o_mem_data_x + bus.o_mem_data_y;

   exp_t        sb[$];
   logic [15:0] mx   [DEPTH];
   logic [15:0] my   [DEPTH];
   logic [15:0] mres [DEPTH];
   logic [15:0] rd_old;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) begin
         mx[i]   = '0;
         my[i]   = '0;
         mres[i] = '0;
      end
      sb.delete();
   endtask

   task automatic write_pair(input int a, input logic [15:0] x, input logic [15:0] y);
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = 3'(a);
      bus.i_wr_x    = x;
      bus.i_wr_y    = y;
      mx[a] = x;
      my[a] = y;
      step();
      bus.i_wr_en = 1'b0;
   endtask

   // Drives Start for one edge and queues the expected results. The read
   // port is parked on the last slot so the same-edge read-old behaviour
   // can be observed when that slot is captured.
   task automatic start_batch(input int n);
      bus.i_start   = 1'b1;
      bus.i_count   = 4'(n);
      bus.i_rd_addr = 3'(n - 1);
      rd_old        = mres[n-1];
      for (int k = 0; k < n; k++) begin
         mres[k] = mx[k] + my[k];
         sb.push_back('{addr: 3'(k), value: mres[k]});
      end
      step();
      bus.i_start = 1'b0;
   endtask

   // Called in cycle 1 (just after the Start edge). Checks Busy/Done every
   // cycle, operands after each ISSUE, and the read port around the final
   // capture. With disturb set, Start and writes are thrown in mid-batch.
   task automatic watch(input int n, input bit disturb);
      int exp_cyc;
      exp_cyc = n * PAIR + 1;
      for (int k = 1; k <= exp_cyc + 2; k++) begin
         check("done", 32'(bus.o_done), 32'(k == exp_cyc));
         check("busy", 32'(bus.o_busy), 32'(k < exp_cyc));
         if (k >= 2 && k < exp_cyc && ((k - 2) % PAIR) == 0) begin
            check("mem_data_x", 32'(bus.o_mem_data_x), 32'(mx[(k-2)/PAIR]));
            check("mem_data_y", 32'(bus.o_mem_data_y), 32'(my[(k-2)/PAIR]));
         end
         if (k == exp_cyc)     check("rd_same_edge_old", 32'(bus.o_rd_data), 32'(rd_old));
         if (k == exp_cyc + 1) check("rd_after_capture", 32'(bus.o_rd_data), 32'(mres[n-1]));
         if (disturb && (k == 3 || k == 7)) begin
            bus.i_start   = 1'b1;
            bus.i_count   = 4'd2;
            bus.i_wr_en   = 1'b1;
            bus.i_wr_addr = (k == 3) ? 3'd2 : 3'd3;
            bus.i_wr_x    = 16'hDEAD;
            bus.i_wr_y    = 16'hBEEF;
         end
         step();
         bus.i_start = 1'b0;
         bus.i_wr_en = 1'b0;
      end
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         bus.i_rd_addr = e.addr;
         step();
         check($sformatf("result[%0d]", e.addr), 32'(bus.o_rd_data), 32'(e.value));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},  32'(bus.o_busy),       32'd0);
      check({tag, "_done"},  32'(bus.o_done),       32'd0);
      check({tag, "_mem_x"}, 32'(bus.o_mem_data_x), 32'd0);
      check({tag, "_mem_y"}, 32'(bus.o_mem_data_y), 32'd0);
      check({tag, "_rd"},    32'(bus.o_rd_data),    32'd0);
   endtask

   initial begin
      bus.i_wr_en   = 1'b0;
      bus.i_wr_addr = '0;
      bus.i_wr_x    = '0;
      bus.i_wr_y    = '0;
      bus.i_start   = 1'b0;
      bus.i_count   = '0;
      bus.i_rd_addr = '0;
      clear_model();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      step();

      // Single signed pair: -13 + -9 = -22
      write_pair(0, 16'hFFF3, 16'hFFF7);
      start_batch(1);
      watch(1, 1'b0);
      check("hold_mem_x", 32'(bus.o_mem_data_x), 32'h0000FFF3);
      check("hold_mem_y", 32'(bus.o_mem_data_y), 32'h0000FFF7);
      drain();

      // Full batch of (k, 2k) -> 3k
      for (int k = 0; k < DEPTH; k++) write_pair(k, 16'(k), 16'(2 * k));
      start_batch(8);
      watch(8, 1'b0);
      drain();

      // Invalid counts are ignored
      bus.i_start = 1'b1;
      bus.i_count = 4'd0;
      step();
      bus.i_count = 4'd9;
      step();
      bus.i_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("bad_count_busy", 32'(bus.o_busy), 32'd0);
         check("bad_count_done", 32'(bus.o_done), 32'd0);
         step();
      end

      // Start and writes during a 4-pair batch are ignored
      for (int k = 0; k < 4; k++) write_pair(k, 16'h1000 + 16'(k), 16'h0100 * 16'(k + 1));
      start_batch(4);
      watch(4, 1'b1);
      drain();
      start_batch(4);
      watch(4, 1'b0);
      drain();

      // Reset during WAIT of pair 2 abandons the batch
      for (int k = 0; k < 4; k++) write_pair(k, 16'h0100 + 16'(k), 16'h0020 + 16'(k));
      start_batch(4);
      repeat (4) step();
      check("pre_reset_busy", 32'(bus.o_busy), 32'd1);
      rst = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      clear_model();
      for (int k = 0; k < 3; k++) begin
         step();
         check("reset_held_done", 32'(bus.o_done), 32'd0);
      end
      rst = 1'b0;
      start_batch(2);
      watch(2, 1'b0);
      sb.push_back('{addr: 3'd5, value: 16'h0000});
      sb.push_back('{addr: 3'd7, value: 16'h0000});
      drain();
      for (int k = 0; k < 4; k++) write_pair(k, 16'h7FFF - 16'(k), 16'h0003 + 16'(k));
      start_batch(4);
      watch(4, 1'b0);
      drain();

      // Write and Start in the same idle cycle: batch uses the new data
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = 3'd0;
      bus.i_wr_x    = 16'h0001;
      bus.i_wr_y    = 16'h0002;
      mx[0] = 16'h0001;
      my[0] = 16'h0002;
      start_batch(1);
      bus.i_wr_en = 1'b0;
      watch(1, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
